// File: rtl/period_meter.sv
// Period meter: measures clock cycles between rising edges of an asynchronous pulse input,
// latching the period, a 2-bit speed code and a wrapping count of completed measurements.
module period_meter #(
   parameter int unsigned MAX_PERIOD = 32'd200000001,
   parameter int unsigned TH_01      = 32'd25000000,
   parameter int unsigned TH_10      = 32'd75000000,
   parameter int unsigned TH_11      = 32'd150000000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        sig_in,
   output logic [31:0] period,
   output logic [1:0]  code,
   output logic        valid,
   output logic        timeout,
   output logic [3:0]  events
);

   typedef enum logic [0:0] {StIdle, StMeasure} state_e;

   state_e      state_q, state_d;
   logic        s1_q, s2_q, s3_q;
   logic        rise;
   logic [31:0] count_q, count_d;
   logic [31:0] period_q, period_d;
   logic [1:0]  code_q, code_d;
   logic        valid_q, valid_d;
   logic        timeout_q, timeout_d;
   logic [3:0]  events_q, events_d;

   function automatic logic [1:0] speed_code(input logic [31:0] p);
      if (p < TH_01)      return 2'b00;
      else if (p < TH_10) return 2'b01;
      else if (p < TH_11) return 2'b10;
      else                return 2'b11;
   endfunction

   // Two-flop synchroniser plus one delay stage for edge detection; runs regardless of enable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= sig_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      period_d  = period_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      events_d  = events_q;
      unique case (state_q)
         StIdle: begin
            if (rise && enable) begin
               count_d = 32'd1;
               state_d = StMeasure;
            end
         end
         StMeasure: begin
            if (!enable) begin
               count_d = 32'd0;
               state_d = StIdle;
            end else if (rise) begin
               // A rise on the timeout cycle still completes the measurement.
               period_d = count_q;
               code_d   = speed_code(count_q);
               valid_d  = 1'b1;
               events_d = events_q + 4'd1;
               count_d  = 32'd1;
            end else if (count_q == MAX_PERIOD) begin
               timeout_d = 1'b1;
               count_d   = 32'd0;
               state_d   = StIdle;
            end else begin
               count_d = count_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         count_q   <= 32'd0;
         period_q  <= 32'd0;
         code_q    <= 2'b00;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         events_q  <= 4'd0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         period_q  <= period_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         events_q  <= events_d;
      end
   end

   assign period  = period_q;
   assign code    = code_q;
   assign valid   = valid_q;
   assign timeout = timeout_q;
   assign events  = events_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: interval-based reference model compared every cycle,
// plus literal expectations at the directed scenarios and randomized pulse trains.
module tb_period_meter;

   localparam int unsigned MaxP = 100;
   localparam int unsigned T01  = 10;
   localparam int unsigned T10  = 20;
   localparam int unsigned T11  = 30;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        sig_in = 1'b0;
   logic [31:0] period;
   logic [1:0]  code;
   logic        valid;
   logic        timeout;
   logic [3:0]  events;

   int checks = 0;
   int errors = 0;

   period_meter #(
      .MAX_PERIOD(MaxP),
      .TH_01     (T01),
      .TH_10     (T10),
      .TH_11     (T11)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .enable (enable),
      .sig_in (sig_in),
      .period (period),
      .code   (code),
      .valid  (valid),
      .timeout(timeout),
      .events (events)
   );

   always #5 clock = ~clock;

   // Reference model: a measurement is an open interval starting at the edge where a rise
   // was accepted; outputs follow from elapsed edge count.
   longint cyc = 0;
   longint start_cyc = 0;
   bit     measuring = 0;
   bit     h1 = 0, h2 = 0, h3 = 0;
   bit     m_valid = 0, m_timeout = 0;
   longint m_period = 0;
   int     m_code = 0;
   int     m_events = 0;
   int     n_timeouts = 0;
   logic [1:0] seen_codes[$];

   function automatic int ref_code(input longint p);
      if (p < T01) return 0;
      if (p < T10) return 1;
      if (p < T11) return 2;
      return 3;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      measuring = 0;
      h1 = 0; h2 = 0; h3 = 0;
      m_valid = 0; m_timeout = 0;
      m_period = 0; m_code = 0; m_events = 0;
   endtask

   always @(negedge reset_n) model_clear();

   always @(posedge clock) begin
      bit     rise;
      longint el;
      cyc++;
      if (!reset_n) begin
         model_clear();
      end else begin
         // Rise seen by the FSM at this edge: input sampled high two edges ago, low three ago.
         rise = h2 & ~h3;
         h3 = h2; h2 = h1; h1 = sig_in;
         m_valid = 0;
         m_timeout = 0;
         el = cyc - start_cyc;
         if (!measuring) begin
            if (rise && enable) begin
               measuring = 1;
               start_cyc = cyc;
            end
         end else if (!enable) begin
            measuring = 0;
         end else if (rise) begin
            m_period = el;
            m_code = ref_code(el);
            m_valid = 1;
            m_events = (m_events + 1) % 16;
            start_cyc = cyc;
         end else if (el == MaxP) begin
            m_timeout = 1;
            measuring = 0;
         end
      end
      #1;
      check("valid", valid, m_valid);
      check("timeout", timeout, m_timeout);
      check("period", period, m_period);
      check("code", code, m_code);
      check("events", events, m_events);
      if (timeout === 1'b1) n_timeouts++;
      if (valid === 1'b1) seen_codes.push_back(code);
   end

   // Rising edges of sig_in spaced exactly gap cycles apart when called back to back.
   task automatic pulse(input int gap);
      int hi;
      hi = (gap >= 4) ? 2 : 1;
      sig_in = 1'b1;
      repeat (hi) @(negedge clock);
      sig_in = 1'b0;
      repeat (gap - hi) @(negedge clock);
   endtask

   logic [1:0] exp_codes[6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
   int         to_before;

   initial begin
      repeat (3) @(negedge clock);
      check("reset_period", period, 0);
      check("reset_code", code, 0);
      check("reset_valid", valid, 0);
      check("reset_events", events, 0);
      reset_n = 1'b1;
      enable = 1'b1;
      @(negedge clock);

      // Pulses 4 apart: first rise opens, the next three each complete.
      repeat (4) pulse(4);
      repeat (5) @(negedge clock);
      check("t1_period", period, 4);
      check("t1_code", code, 0);
      check("t1_events", events, 3);

      // Last measurement left open: it must time out once and keep the results.
      repeat (120) @(negedge clock);
      check("t2_timeouts", n_timeouts, 1);
      check("t2_period", period, 4);
      check("t2_events", events, 3);

      // Threshold boundaries.
      seen_codes.delete();
      pulse(9); pulse(10); pulse(19); pulse(20); pulse(29); pulse(30); pulse(4);
      repeat (5) @(negedge clock);
      check("t4_count", seen_codes.size(), 6);
      for (int i = 0; i < 6 && i < seen_codes.size(); i++)
         check("t4_code", seen_codes[i], exp_codes[i]);
      check("t4_period", period, 30);
      repeat (120) @(negedge clock);

      // Rises exactly MAX_PERIOD apart complete rather than time out.
      to_before = n_timeouts;
      pulse(100); pulse(100); pulse(4);
      repeat (5) @(negedge clock);
      check("t3_period", period, 100);
      check("t3_code", code, 3);
      check("t3_no_timeout", n_timeouts, to_before);
      repeat (120) @(negedge clock);

      // Enable dropped mid-measurement.
      pulse(10);
      repeat (10) @(negedge clock);
      enable = 1'b0;
      repeat (5) @(negedge clock);
      enable = 1'b1;
      repeat (120) @(negedge clock);

      // Asynchronous reset between edges during a measurement.
      pulse(10); pulse(10);
      repeat (20) @(negedge clock);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("rst_period", period, 0);
      check("rst_code", code, 0);
      check("rst_valid", valid, 0);
      check("rst_timeout", timeout, 0);
      check("rst_events", events, 0);
      #1 reset_n = 1'b1;
      @(negedge clock);
      pulse(20); pulse(20); pulse(4);
      repeat (5) @(negedge clock);
      check("rst_after_period", period, 20);
      check("rst_after_events", events, 2);
      repeat (120) @(negedge clock);

      // Randomized pulse trains with occasional enable drops.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(15) == 0) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clock);
            enable = 1'b1;
         end
         pulse(int'($urandom_range(2, 130)));
      end
      repeat (150) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
